eth_tx_arb: RTL and testbench
=============================

Name: eth_tx_arb

Overview:
- Packet-granular round-robin arbiter sharing one 64-bit Ethernet TX stream (MAC TX AXI-Stream) among NSRC encapsulator-style sources, e.g. several TLP snoop/encap channels.
- A grant, once taken, is held from the first beat to the tlast beat, so frames never interleave.
- Sits between the eth_encap-class producers and the MAC TX interface, in the eth_clk domain.
- Provides a per-source enable mask and per-source frame counters for configuration and monitoring.

Parameters:
- NSRC, 4, number of requesting sources (2..8).
- CNT_W, 32, width of each per-source frame counter.

Ports:
- eth_clk  in  1  clock.
- eth_rst  in  1  synchronous, active-high reset.
- src_en  in  NSRC  per-source enable; sampled only when arbitrating.
- s_tvalid  in  NSRC  per-source beat valid.
- s_tlast  in  NSRC  per-source last beat.
- s_tkeep  in  8*NSRC  per-source byte keep; source i occupies [8i+7:8i].
- s_tdata  in  64*NSRC  per-source data; source i occupies [64i+63:64i].
- s_tuser  in  NSRC  per-source tuser (TX error flag).
- s_tready  out  NSRC  per-source ready.
- eth_tready  in  1  MAC ready.
- eth_tvalid  out  1  merged valid.
- eth_tlast  out  1  merged last.
- eth_tkeep  out  8  merged keep.
- eth_tdata  out  64  merged data.
- eth_tuser  out  1  merged tuser.
- grant_idx  out  clog2(NSRC)  index of the current or last granted source.
- busy  out  1  high while a frame is in flight.
- frm_cnt  out  CNT_W*NSRC  per-source count of completed frames.

Behaviour:
- Reset (synchronous; takes effect at the first eth_clk edge with eth_rst high):
  - state = ARB_IDLE, rr_ptr = 0, grant_idx = 0, busy = 0, all frm_cnt = 0.
  - Merged outputs and s_tready read 0 in the cycle after that edge.
- Reset mid-frame: the frame is abandoned. The downstream sees a truncated frame without tlast; MAC-side error handling is not this block's concern.
- States: ARB_IDLE, ARB_BUSY.
- ARB_IDLE:
  - All outputs are 0.
  - req = s_tvalid & src_en.
  - If req is nonzero, pick the first set bit searching from rr_ptr upward with wrap-around.
  - Register the pick into grant_idx, set busy = 1, go to ARB_BUSY.
  - This gives one bubble cycle per frame: first beat latency is 1 cycle after tvalid is seen.
- ARB_BUSY, combinational pass-through from source g = grant_idx:
  - eth_tvalid = s_tvalid[g]; eth_tlast, eth_tkeep, eth_tdata and eth_tuser come from the slices of g.
  - s_tready[g] = eth_tready; every other s_tready bit = 0.
  - Beat transfer is eth_tvalid & eth_tready.
  - If s_tvalid[g] drops mid-frame, the grant is held and eth_tvalid follows it low; no timeout.
  - Deasserting src_en[g] mid-frame has no effect; the frame completes.
  - On a transfer with eth_tlast = 1, at the next edge:
    - frm_cnt[g] += 1, wrapping at 2^CNT_W.
    - rr_ptr = (g+1) mod NSRC.
    - busy = 0; go to ARB_IDLE.
- Sources must assert s_tvalid without waiting for s_tready (AXI rule). An eth_encap-class source presents header beats with tvalid already high, which satisfies this.
- Fairness: with all sources continuously requesting, grants rotate 0,1,2,…,NSRC-1,0,… with one frame each.
- Single-beat frame (tvalid & tlast on the first beat) is legal and completes in one BUSY cycle.
- rr_ptr only advances on frame completion, never on reset-abandoned frames.
- No combinational path from eth_tready to any s_tvalid-dependent arbitration decision. The IDLE pick depends only on registered rr_ptr, s_tvalid and src_en.

Decomposition:
- In ethernet_pkg or a new arb_pkg:
  - typedef ARB_STATE (ARB_IDLE, ARB_BUSY).
  - Function rr_pick(req, ptr) returning index and found flag.
- Reuse the existing ETH_TDATA64, ETH_TKEEP64 and ETH_TUSER64_TX types for the merged port.
- One natural sub-module: rr_arbiter, a parameterised priority-rotate picker (combinational). State, mux and counters stay in eth_tx_arb.

Test Plan:
- Single source 1 requests a 3-beat frame, eth_tready = 1:
  - grant_idx = 1 one cycle after s_tvalid[1].
  - Beats appear in order with matching data, keep and tlast.
  - frm_cnt[1] = 1, rr_ptr = 2.
- All four sources continuously valid, 2-beat frames each, 12 frames:
  - Grant sequence 0,1,2,3,0,1,2,3,0,1,2,3.
  - Each frm_cnt = 3.
  - No beat interleaving; s_tready is one-hot or zero at all times.
- Backpressure: eth_tready toggles 1,0,0,1,… during a 4-beat frame from source 2:
  - s_tready[2] mirrors eth_tready.
  - Data is stable while stalled; exactly 4 transfers.
- src_en = 4'b1011 with all sources valid: source 2 is never granted. Clearing src_en[0] mid-frame of source 0: that frame completes with tlast.
- eth_rst pulsed for 1 cycle during beat 2 of 5 of source 3:
  - Next cycle all outputs 0, busy = 0, grant_idx = 0, frm_cnt all 0.
  - A new request from source 3 is granted cleanly afterwards.
- With CNT_W overridden to 4, source 0 sends 17 frames: frm_cnt[0] wraps and reads 1.

Source files
------------

// File: rtl/eth_tx_arb_pkg.sv
// Shared types and the round-robin pick helper for the Ethernet TX arbiter.
package eth_tx_arb_pkg;

    typedef logic [63:0] ETH_TDATA64;
    typedef logic [7:0]  ETH_TKEEP64;
    typedef logic        ETH_TUSER64_TX;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } ARB_STATE;

    // Largest supported source count; the picker works on a fixed-width view.
    localparam int RR_MAX = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of req searching upward from ptr, wrapping at n.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        ptr,
                                         input logic [3:0]        n);
        rr_pick_t   r;
        logic [3:0] j;
        r = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            j = {1'b0, ptr} + 4'(k);
            if (j >= n) j = j - n;
            if ((4'(k) < n) && !r.found && req[j[2:0]]) begin
                r.found = 1'b1;
                r.idx   = j[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_tx_arb_rr_arbiter.sv
// Combinational rotating-priority picker; no state of its own.
module rr_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0]         req,
    input  logic [$clog2(NSRC)-1:0] ptr,
    output logic                    found,
    output logic [$clog2(NSRC)-1:0] idx
);
    localparam int IW = $clog2(NSRC);

    rr_pick_t pick;

    // Evaluate the rotate search on the zero-extended request vector.
    always_comb begin
        pick = rr_pick(RR_MAX'(req), 3'(ptr), 4'(NSRC));
    end

    assign found = pick.found;
    assign idx   = IW'(pick.idx);

endmodule

// File: rtl/eth_tx_arb.sv
// Packet-granular round-robin arbiter merging NSRC AXI-Stream sources onto the MAC TX stream.
//
//   state    | meaning
//   ARB_IDLE | no frame in flight; pick next requester, all outputs low
//   ARB_BUSY | frame from grant_idx passes straight through until its tlast beat
module eth_tx_arb
    import eth_tx_arb_pkg::*;
#(
    parameter int NSRC  = 4,
    parameter int CNT_W = 32
) (
    input  logic                    eth_clk,
    input  logic                    eth_rst,
    input  logic [NSRC-1:0]         src_en,
    input  logic [NSRC-1:0]         s_tvalid,
    input  logic [NSRC-1:0]         s_tlast,
    input  logic [8*NSRC-1:0]       s_tkeep,
    input  logic [64*NSRC-1:0]      s_tdata,
    input  logic [NSRC-1:0]         s_tuser,
    output logic [NSRC-1:0]         s_tready,
    input  logic                    eth_tready,
    output logic                    eth_tvalid,
    output logic                    eth_tlast,
    output ETH_TKEEP64              eth_tkeep,
    output ETH_TDATA64              eth_tdata,
    output ETH_TUSER64_TX           eth_tuser,
    output logic [$clog2(NSRC)-1:0] grant_idx,
    output logic                    busy,
    output logic [CNT_W*NSRC-1:0]   frm_cnt
);
    localparam int IW = $clog2(NSRC);

    ARB_STATE                    state, state_nxt;
    logic [IW-1:0]               rr_ptr, grant_q, pick_idx;
    logic                        pick_found;
    logic                        xfer_last;
    logic [NSRC-1:0]             req;
    logic [NSRC-1:0][63:0]       data_v;
    logic [NSRC-1:0][7:0]        keep_v;
    logic [NSRC-1:0][CNT_W-1:0]  cnt_q;

    assign data_v    = s_tdata;
    assign keep_v    = s_tkeep;
    assign req       = s_tvalid & src_en;
    assign frm_cnt   = cnt_q;
    assign grant_idx = grant_q;
    assign busy      = (state == ARB_BUSY);

    // The pick sees only registered rr_ptr plus valid/enable, never eth_tready.
    rr_arbiter #(.NSRC(NSRC)) u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state logic and the granted-source pass-through mux.
    always_comb begin
        state_nxt  = state;
        eth_tvalid = 1'b0;
        eth_tlast  = 1'b0;
        eth_tkeep  = '0;
        eth_tdata  = '0;
        eth_tuser  = 1'b0;
        s_tready   = '0;
        xfer_last  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_found) state_nxt = ARB_BUSY;
            end
            ARB_BUSY: begin
                eth_tvalid         = s_tvalid[grant_q];
                eth_tlast          = s_tlast[grant_q];
                eth_tkeep          = keep_v[grant_q];
                eth_tdata          = data_v[grant_q];
                eth_tuser          = s_tuser[grant_q];
                s_tready[grant_q]  = eth_tready;
                xfer_last          = s_tvalid[grant_q] & eth_tready & s_tlast[grant_q];
                if (xfer_last) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State, grant, rotate pointer and frame counters; a reset abandons any frame in flight.
    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && pick_found) grant_q <= pick_idx;
            if (xfer_last) begin
                cnt_q[grant_q] <= cnt_q[grant_q] + CNT_W'(1);
                rr_ptr         <= (grant_q == IW'(NSRC-1)) ? '0 : grant_q + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: cycle vector table plus multi-frame sequences.
module tb_eth_tx_arb;
    import eth_tx_arb_pkg::*;

    localparam int NSRC  = 4;
    localparam int CNT_W = 4;

    logic                  eth_clk = 1'b0;
    logic                  eth_rst;
    logic [NSRC-1:0]       src_en;
    logic [NSRC-1:0]       s_tvalid;
    logic [NSRC-1:0]       s_tlast;
    logic [8*NSRC-1:0]     s_tkeep;
    logic [64*NSRC-1:0]    s_tdata;
    logic [NSRC-1:0]       s_tuser;
    logic [NSRC-1:0]       s_tready;
    logic                  eth_tready;
    logic                  eth_tvalid;
    logic                  eth_tlast;
    logic [7:0]            eth_tkeep;
    logic [63:0]           eth_tdata;
    logic                  eth_tuser;
    logic [1:0]            grant_idx;
    logic                  busy;
    logic [CNT_W*NSRC-1:0] frm_cnt;

    always #5 eth_clk = ~eth_clk;

    eth_tx_arb #(.NSRC(NSRC), .CNT_W(CNT_W)) dut (
        .eth_clk    (eth_clk),
        .eth_rst    (eth_rst),
        .src_en     (src_en),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tkeep    (s_tkeep),
        .s_tdata    (s_tdata),
        .s_tuser    (s_tuser),
        .s_tready   (s_tready),
        .eth_tready (eth_tready),
        .eth_tvalid (eth_tvalid),
        .eth_tlast  (eth_tlast),
        .eth_tkeep  (eth_tkeep),
        .eth_tdata  (eth_tdata),
        .eth_tuser  (eth_tuser),
        .grant_idx  (grant_idx),
        .busy       (busy),
        .frm_cnt    (frm_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dat(input int src, input int beat);
        return {8'hA0 + 8'(src), 40'h0, 8'(src), 8'(beat)};
    endfunction

    function automatic logic [7:0] keep_of(input logic last);
        return last ? 8'h0F : 8'hFF;
    endfunction

    task automatic set_src(input int i, input logic v, input logic l, input int beat);
        logic [31:0] b;
        b = beat;
        s_tvalid[i]         = v;
        s_tlast[i]          = l;
        s_tdata[64*i +: 64] = dat(i, beat);
        s_tkeep[8*i +: 8]   = keep_of(l);
        s_tuser[i]          = b[0];
    endtask

    // ---------------- cycle vector table ----------------
    typedef struct {
        logic [3:0] en;
        logic [3:0] valid;
        logic [3:0] last;
        logic       ready;
        int         beat;
        logic       exp_tvalid;
        logic       exp_tlast;
        logic [3:0] exp_sready;
        logic [1:0] exp_grant;
        logic       exp_busy;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[15];

    // ---------------- frame generator for sequences ----------------
    int nfr[NSRC];
    int len[NSRC];
    int bc[NSRC];
    int gq[$];
    int n_xfer;
    int ready_mode;
    int cyc;

    task automatic gen_drive();
        logic v;
        for (int i = 0; i < NSRC; i++) begin
            v = (nfr[i] > 0);
            set_src(i, v, v && (bc[i] == len[i] - 1), bc[i]);
        end
        eth_tready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    endtask

    task automatic gen_clear();
        for (int i = 0; i < NSRC; i++) begin
            nfr[i] = 0;
            len[i] = 1;
            bc[i]  = 0;
        end
        gq.delete();
        n_xfer = 0;
        cyc    = 0;
    endtask

    task automatic run(input int max_cyc, input bit expect_done);
        logic [3:0] hs;
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            gen_drive();
            @(negedge eth_clk);
            hs = s_tvalid & s_tready;
            check("sready_onehot0", $onehot0(s_tready), 1'b1);
            if (busy) check("sready_mirror", s_tready[grant_idx], eth_tready);
            if (eth_tvalid) begin
                check("seq_data", eth_tdata, dat(grant_idx, bc[grant_idx]));
                check("seq_tlast", eth_tlast, bc[grant_idx] == len[grant_idx] - 1);
            end
            if (eth_tvalid && eth_tready) begin
                n_xfer++;
                if (eth_tlast) gq.push_back(int'(grant_idx));
            end
            @(posedge eth_clk);
            #1;
            cyc++;
            for (int i = 0; i < NSRC; i++) begin
                if (hs[i]) begin
                    bc[i]++;
                    if (bc[i] == len[i]) begin
                        bc[i] = 0;
                        nfr[i]--;
                    end
                end
            end
            done = 1'b1;
            for (int i = 0; i < NSRC; i++) if (nfr[i] > 0) done = 1'b0;
        end
        if (expect_done) check("run_done", done, 1'b1);
    endtask

    task automatic do_reset();
        gen_clear();
        eth_rst    = 1'b1;
        s_tvalid   = '0;
        s_tlast    = '0;
        s_tkeep    = '0;
        s_tdata    = '0;
        s_tuser    = '0;
        eth_tready = 1'b0;
        src_en     = 4'hF;
        @(posedge eth_clk);
        #1;
        eth_rst    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int twos;
        ready_mode = 0;
        do_reset();

        // en, valid, last, ready, beat | tvalid, tlast, sready, grant, busy, frm_cnt
        tbl[0]  = '{4'hF, 4'h2, 4'h0, 1'b1, 0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 16'h0000};
        tbl[1]  = '{4'hF, 4'h2, 4'h0, 1'b1, 0, 1'b1, 1'b0, 4'h2, 2'd1, 1'b1, 16'h0000};
        tbl[2]  = '{4'hF, 4'h2, 4'h0, 1'b1, 1, 1'b1, 1'b0, 4'h2, 2'd1, 1'b1, 16'h0000};
        tbl[3]  = '{4'hF, 4'h2, 4'h2, 1'b1, 2, 1'b1, 1'b1, 4'h2, 2'd1, 1'b1, 16'h0000};
        tbl[4]  = '{4'hF, 4'h0, 4'h0, 1'b1, 0, 1'b0, 1'b0, 4'h0, 2'd1, 1'b0, 16'h0010};
        tbl[5]  = '{4'hF, 4'hD, 4'hD, 1'b1, 0, 1'b0, 1'b0, 4'h0, 2'd1, 1'b0, 16'h0010};
        tbl[6]  = '{4'hF, 4'hD, 4'hD, 1'b1, 0, 1'b1, 1'b1, 4'h4, 2'd2, 1'b1, 16'h0010};
        tbl[7]  = '{4'hF, 4'h9, 4'h9, 1'b1, 0, 1'b0, 1'b0, 4'h0, 2'd2, 1'b0, 16'h0110};
        tbl[8]  = '{4'hF, 4'h9, 4'h9, 1'b1, 0, 1'b1, 1'b1, 4'h8, 2'd3, 1'b1, 16'h0110};
        tbl[9]  = '{4'hF, 4'h0, 4'h0, 1'b1, 0, 1'b0, 1'b0, 4'h0, 2'd3, 1'b0, 16'h1110};
        tbl[10] = '{4'hE, 4'h1, 4'h1, 1'b0, 0, 1'b0, 1'b0, 4'h0, 2'd3, 1'b0, 16'h1110};
        tbl[11] = '{4'hF, 4'h1, 4'h1, 1'b0, 0, 1'b0, 1'b0, 4'h0, 2'd3, 1'b0, 16'h1110};
        tbl[12] = '{4'hF, 4'h1, 4'h1, 1'b0, 0, 1'b1, 1'b1, 4'h0, 2'd0, 1'b1, 16'h1110};
        tbl[13] = '{4'hF, 4'h1, 4'h1, 1'b1, 0, 1'b1, 1'b1, 4'h1, 2'd0, 1'b1, 16'h1110};
        tbl[14] = '{4'hF, 4'h0, 4'h0, 1'b1, 0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 16'h1111};

        for (int v = 0; v < 15; v++) begin
            logic [31:0] b;
            b      = tbl[v].beat;
            src_en = tbl[v].en;
            for (int i = 0; i < NSRC; i++)
                set_src(i, tbl[v].valid[i], tbl[v].last[i], tbl[v].beat);
            eth_tready = tbl[v].ready;
            @(negedge eth_clk);
            check("vec_tvalid", eth_tvalid, tbl[v].exp_tvalid);
            check("vec_tlast",  eth_tlast,  tbl[v].exp_tlast);
            check("vec_sready", s_tready,   tbl[v].exp_sready);
            check("vec_grant",  grant_idx,  tbl[v].exp_grant);
            check("vec_busy",   busy,       tbl[v].exp_busy);
            check("vec_frm_cnt", frm_cnt,   tbl[v].exp_cnt);
            check("vec_tdata", eth_tdata,
                  tbl[v].exp_tvalid ? dat(int'(tbl[v].exp_grant), tbl[v].beat) : 64'h0);
            check("vec_tkeep", eth_tkeep,
                  tbl[v].exp_tvalid ? keep_of(tbl[v].exp_tlast) : 8'h00);
            check("vec_tuser", eth_tuser, tbl[v].exp_tvalid ? b[0] : 1'b0);
            @(posedge eth_clk);
            #1;
        end

        // Fairness: four sources, 2-beat frames, three frames each.
        do_reset();
        for (int i = 0; i < NSRC; i++) begin
            len[i] = 2;
            nfr[i] = 3;
        end
        run(80, 1'b1);
        gen_drive();
        check("rr_frames", gq.size(), 12);
        for (int k = 0; k < gq.size() && k < 12; k++)
            check("rr_grant_seq", gq[k], k % 4);
        check("rr_frm_cnt", frm_cnt, 16'h3333);

        // Backpressure on a 4-beat frame from source 2.
        do_reset();
        ready_mode = 1;
        len[2] = 4;
        nfr[2] = 1;
        run(40, 1'b1);
        ready_mode = 0;
        gen_drive();
        check("bp_xfers", n_xfer, 4);
        check("bp_frm_cnt", frm_cnt, 16'h0100);

        // Source 2 masked off while everyone requests.
        do_reset();
        src_en = 4'b1011;
        for (int i = 0; i < NSRC; i++) begin
            len[i] = 2;
            nfr[i] = 2;
        end
        run(40, 1'b0);
        twos = 0;
        foreach (gq[k]) if (gq[k] == 2) twos++;
        check("mask_no_src2", twos, 0);
        check("mask_frames", gq.size(), 6);
        if (gq.size() == 6) begin
            check("mask_seq0", gq[0], 0);
            check("mask_seq2", gq[2], 3);
            check("mask_seq3", gq[3], 0);
        end
        check("mask_frm_cnt", frm_cnt, 16'h2022);
        nfr[2] = 0;
        gen_drive();

        // Clearing src_en[0] mid-frame lets the frame finish.
        do_reset();
        len[0] = 3;
        nfr[0] = 1;
        run(2, 1'b0);
        check("en_clear_busy", busy, 1'b1);
        src_en = 4'b1110;
        run(20, 1'b1);
        gen_drive();
        check("en_clear_frames", gq.size(), 1);
        check("en_clear_frm_cnt", frm_cnt, 16'h0001);

        // Reset during beat 2 of a 5-beat frame from source 3.
        do_reset();
        len[1] = 2;
        nfr[1] = 1;
        run(20, 1'b1);
        len[3] = 5;
        nfr[3] = 1;
        for (int k = 0; k < 10 && bc[3] != 1; k++) run(1, 1'b0);
        check("rst_pre_beat", bc[3], 1);
        check("rst_pre_grant", grant_idx, 2'd3);
        gen_drive();
        eth_rst = 1'b1;
        @(posedge eth_clk);
        #1;
        eth_rst = 1'b0;
        check("rst_tvalid", eth_tvalid, 1'b0);
        check("rst_sready", s_tready, 4'h0);
        check("rst_tdata", eth_tdata, 64'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant_idx, 2'd0);
        check("rst_frm_cnt", frm_cnt, 16'h0000);
        bc[3]  = 0;
        nfr[3] = 1;
        gq.delete();
        run(20, 1'b1);
        gen_drive();
        check("rst_regrant_frames", gq.size(), 1);
        if (gq.size() == 1) check("rst_regrant_src", gq[0], 3);
        check("rst_regrant_cnt", frm_cnt, 16'h1000);

        // 4-bit counter wraps after 17 single-beat frames.
        do_reset();
        len[0] = 1;
        nfr[0] = 17;
        run(100, 1'b1);
        gen_drive();
        check("wrap_frames", gq.size(), 17);
        check("wrap_frm_cnt", frm_cnt, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
